fp_mul_pipe: RTL and testbench
==============================

// Module: fp_mul_pipe
// PURPOSE
//  Parametrised IEEE-754 binary multiplier; 3-stage pipeline with valid/ready flow control at both ends.
//  Supports runtime rounding mode, signed-zero/Inf/NaN handling and sticky-style exception flags.
//  Sits in the fp32_core lane datapath; a per-op tag travels with each result for writeback routing.
// PARAMETERS
//  EXP_WIDTH   8   exponent bits (8/23 = FP32, 5/10 = FP16, 8/7 = BF16)
//  MANT_WIDTH  23  stored fraction bits (hidden bit excluded)
//  TAG_WIDTH   4   opaque tag width, passed through unchanged
// PORTS
//  clk        in   1                    clock, rising edge
//  rst_n      in   1                    reset, asynchronous, active-low
//  in_valid   in   1                    operand beat valid
//  in_ready   out  1                    block can accept a beat this cycle
//  a, b       in   1+EXP_WIDTH+MANT_WIDTH  operands, {sign,exp,frac}
//  rm         in   2                    round mode: 0 RNE, 1 RTZ, 2 RUP(+inf), 3 RDN(-inf)
//  in_tag     in   TAG_WIDTH            tag sampled with the beat
//  out_valid  out  1                    result valid
//  out_ready  in   1                    consumer accepts result
//  result     out  1+EXP_WIDTH+MANT_WIDTH  product
//  out_tag    out  TAG_WIDTH            tag of this result
//  flags      out  4                    {invalid, overflow, underflow, inexact} for this result
// BEHAVIOUR
//  Reset: all stage valids 0; out_valid=0, result=0, out_tag=0, flags=0; in_ready=1 after reset.
//  Handshake: beat accepted when in_valid&&in_ready; result consumed when out_valid&&out_ready.
//  Stage k loads when empty or when stage k+1 loads/drains that cycle (per-stage valids, no bubbles).
//  in_ready = !v1 || stage1 advances (combinational from out_ready through v2,v3; no in_valid dependency).
//  Latency 3 cycles accept->out_valid when unstalled; throughput 1/cycle.
//  result/out_tag/flags held stable while out_valid && !out_ready.
//  Async reset mid-operation discards all in-flight beats; no partial output.
//  S1: unpack, classify (zero/sub/inf/qNaN/sNaN), sign = a.s ^ b.s, register rm and tag.
//   Subnormal inputs are flushed to signed zero (no flag).
//  S2: product (MANT_WIDTH+1)^2 -> 2*MANT_WIDTH+2 bits; exp = ea+eb-BIAS, signed EXP_WIDTH+2 bits.
//  S3: normalise (MSB at bit 2M+1 -> shift 1, exp+1), G/R/S from discarded bits, round per rm:
//   RNE: up if G&&(R||S||L); RTZ: never; RUP: up if !sign&&(G||R||S); RDN: up if sign&&(G||R||S).
//   Rounding carry out of the fraction: frac=0, exp+1, then re-check overflow.
//   inexact = G||R||S (also set on every overflow/underflow).
//   exp >= 2^EXP_WIDTH-1: overflow; RNE->Inf; RTZ->max finite; RUP->+Inf or -max; RDN->-Inf or +max.
//   exp <= 0 after rounding: flush to signed zero, underflow=1, inexact=1.
//  Specials (priority order): any NaN or 0*Inf -> canonical qNaN {0,all1s,1,0..}.
//   invalid=1 on sNaN operand or 0*Inf; qNaN operand alone gives invalid=0.
//   Inf*nonzero -> signed Inf, no flags; zero*finite -> signed zero, no flags.
// STRUCTURE
//  fp_pkg: rm_e enum (RM_RNE, RM_RTZ, RM_RUP, RM_RDN), fp_flags_t packed struct,
//   fp_class_t struct {zero,sub,inf,qnan,snan}, BIAS = 2**(EXP_WIDTH-1)-1 derived locally.
//  Sub-module fp_round_pack (combinational): normalise + round + overflow/underflow + pack.
//   Instantiated in S3; reusable by the planned fp_add_pipe.
//  Elaboration check: EXP_WIDTH>=3, MANT_WIDTH>=2, else $fatal.
// TESTING
//  FP32 RNE 0x3FC00000*0x40000000 (1.5*2) -> 0x40400000 (3.0), flags 0, out_valid exactly 3 cycles later.
//  0x3F800001*0x3F800001, RNE -> 0x3F800002, inexact=1; same operands RTZ -> 0x3F800002, inexact=1.
//  0x7F000000*0x40000000: RNE -> 0x7F800000, overflow+inexact; RTZ -> 0x7F7FFFFF; RDN -> 0x7F7FFFFF.
//  0x80000000*0x7F800000 -> 0x7FC00000 invalid=1; 0x7F800001*0x3F800000 -> 0x7FC00000 invalid=1.
//  0x00800000*0x3F000000 (min normal*0.5) -> 0x00000000, underflow+inexact; 0xFF800000*0x40000000 -> 0xFF800000, flags 0.
//  Back-to-back 16 beats, random out_ready stalls: results/tags in order, none lost/duplicated; rst_n pulse mid-burst -> out_valid=0.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types for the floating-point lane datapath
package fp_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } rm_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    typedef struct packed {
        logic zero;
        logic sub;
        logic inf;
        logic qnan;
        logic snan;
    } fp_class_t;

endpackage

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - normalise, round, range-check and pack a raw mantissa product
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23
) (
    input  logic                              sign,
    input  logic signed [EXP_WIDTH+1:0]       exp_in,
    input  logic [2*MANT_WIDTH+1:0]           prod,
    input  rm_e                               rm,
    output logic [EXP_WIDTH+MANT_WIDTH:0]     result,
    output fp_flags_t                         flags
);
    localparam int EW = EXP_WIDTH + 3;
    localparam logic [EW-1:0] EXP_MAX = EW'(2**EXP_WIDTH - 1);

    logic [2*MANT_WIDTH:0]   norm;
    logic [EW-1:0]           exp_n;
    logic [EW-1:0]           exp_r;
    logic [MANT_WIDTH-1:0]   frac;
    logic [MANT_WIDTH:0]     frac_sum;
    logic                    guard;
    logic                    round_bit;
    logic                    sticky;
    logic                    inexact;
    logic                    up;
    logic                    to_inf;

    always_comb begin
        // Product of two [1,2) mantissas lies in [1,4); bring the leading one to the top.
        norm  = prod[2*MANT_WIDTH+1] ? prod[2*MANT_WIDTH:0] : {prod[2*MANT_WIDTH-1:0], 1'b0};
        exp_n = {exp_in[EXP_WIDTH+1], exp_in} + {{(EW-1){1'b0}}, prod[2*MANT_WIDTH+1]};

        frac      = norm[2*MANT_WIDTH:MANT_WIDTH+1];
        guard     = norm[MANT_WIDTH];
        round_bit = norm[MANT_WIDTH-1];
        sticky    = |norm[MANT_WIDTH-2:0];
        inexact   = guard | round_bit | sticky;

        case (rm)
            RM_RNE:  up = guard & (round_bit | sticky | frac[0]);
            RM_RTZ:  up = 1'b0;
            RM_RUP:  up = ~sign & inexact;
            default: up = sign & inexact;
        endcase

        frac_sum = {1'b0, frac} + {{MANT_WIDTH{1'b0}}, up};
        exp_r    = exp_n + {{(EW-1){1'b0}}, frac_sum[MANT_WIDTH]};

        case (rm)
            RM_RNE:  to_inf = 1'b1;
            RM_RTZ:  to_inf = 1'b0;
            RM_RUP:  to_inf = ~sign;
            default: to_inf = sign;
        endcase

        flags         = '0;
        flags.inexact = inexact;
        result        = {sign, exp_r[EXP_WIDTH-1:0], frac_sum[MANT_WIDTH-1:0]};

        if (!exp_r[EW-1] && (exp_r >= EXP_MAX)) begin
            flags.overflow = 1'b1;
            flags.inexact  = 1'b1;
            result = to_inf ? {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}}
                            : {sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};
        end else if (exp_r[EW-1] || (exp_r == '0)) begin
            flags.underflow = 1'b1;
            flags.inexact   = 1'b1;
            result = {sign, {(EXP_WIDTH+MANT_WIDTH){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - three-stage IEEE-754 multiplier with valid/ready at both ends
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]  a,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]  b,
    input  logic [1:0]                     rm,
    input  logic [TAG_WIDTH-1:0]           in_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_WIDTH+MANT_WIDTH:0]  result,
    output logic [TAG_WIDTH-1:0]           out_tag,
    output logic [3:0]                     flags
);
    localparam int W    = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int PW   = 2*MANT_WIDTH + 2;
    localparam int BIAS = 2**(EXP_WIDTH-1) - 1;
    localparam logic [EXP_WIDTH+1:0] BIAS_X = (EXP_WIDTH+2)'(BIAS);

    generate
        if (EXP_WIDTH < 3 || MANT_WIDTH < 2) begin : g_param_check
            $fatal(1, "fp_mul_pipe: EXP_WIDTH must be >= 3 and MANT_WIDTH >= 2");
        end
    endgenerate

    function automatic fp_class_t classify(input logic [EXP_WIDTH-1:0] e,
                                           input logic [MANT_WIDTH-1:0] f);
        fp_class_t c;
        c      = '0;
        c.zero = (e == '0) && (f == '0);
        c.sub  = (e == '0) && (f != '0);
        c.inf  = (&e) && (f == '0);
        c.qnan = (&e) && f[MANT_WIDTH-1];
        c.snan = (&e) && !f[MANT_WIDTH-1] && (f != '0);
        return c;
    endfunction

    logic v1, v2, v3;
    logic s1_free, s2_free, s3_free;

    logic                   s1_sign;
    fp_class_t              s1_cls_a, s1_cls_b;
    logic [EXP_WIDTH-1:0]   s1_exp_a, s1_exp_b;
    logic [MANT_WIDTH:0]    s1_mant_a, s1_mant_b;
    rm_e                    s1_rm;
    logic [TAG_WIDTH-1:0]   s1_tag;

    logic                         s2_sign;
    logic [PW-1:0]                s2_prod;
    logic signed [EXP_WIDTH+1:0]  s2_exp;
    rm_e                          s2_rm;
    logic [TAG_WIDTH-1:0]         s2_tag;
    logic                         s2_nan, s2_invalid, s2_inf, s2_zero;

    logic      a_zero, b_zero, mul_invalid, any_nan;
    logic [W-1:0] rp_result, s3_result_d;
    fp_flags_t rp_flags, s3_flags_d, s3_flags;

    // A stage may load whenever it is empty or its contents move on this cycle.
    assign s3_free   = !v3 || out_ready;
    assign s2_free   = !v2 || s3_free;
    assign s1_free   = !v1 || s2_free;
    assign in_ready  = s1_free;
    assign out_valid = v3;
    assign flags     = s3_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            s1_sign   <= 1'b0;
            s1_cls_a  <= '0;
            s1_cls_b  <= '0;
            s1_exp_a  <= '0;
            s1_exp_b  <= '0;
            s1_mant_a <= '0;
            s1_mant_b <= '0;
            s1_rm     <= RM_RNE;
            s1_tag    <= '0;
        end else if (s1_free) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sign   <= a[W-1] ^ b[W-1];
                s1_cls_a  <= classify(a[W-2:MANT_WIDTH], a[MANT_WIDTH-1:0]);
                s1_cls_b  <= classify(b[W-2:MANT_WIDTH], b[MANT_WIDTH-1:0]);
                s1_exp_a  <= a[W-2:MANT_WIDTH];
                s1_exp_b  <= b[W-2:MANT_WIDTH];
                s1_mant_a <= {1'b1, a[MANT_WIDTH-1:0]};
                s1_mant_b <= {1'b1, b[MANT_WIDTH-1:0]};
                s1_rm     <= rm_e'(rm);
                s1_tag    <= in_tag;
            end
        end
    end

    // Subnormal operands count as zero from here on.
    always_comb begin
        a_zero      = s1_cls_a.zero | s1_cls_a.sub;
        b_zero      = s1_cls_b.zero | s1_cls_b.sub;
        mul_invalid = (a_zero & s1_cls_b.inf) | (s1_cls_a.inf & b_zero);
        any_nan     = s1_cls_a.qnan | s1_cls_a.snan | s1_cls_b.qnan | s1_cls_b.snan;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2         <= 1'b0;
            s2_sign    <= 1'b0;
            s2_prod    <= '0;
            s2_exp     <= '0;
            s2_rm      <= RM_RNE;
            s2_tag     <= '0;
            s2_nan     <= 1'b0;
            s2_invalid <= 1'b0;
            s2_inf     <= 1'b0;
            s2_zero    <= 1'b0;
        end else if (s2_free) begin
            v2 <= v1;
            if (v1) begin
                s2_sign    <= s1_sign;
                s2_prod    <= {{(MANT_WIDTH+1){1'b0}}, s1_mant_a} * {{(MANT_WIDTH+1){1'b0}}, s1_mant_b};
                s2_exp     <= $signed({2'b00, s1_exp_a} + {2'b00, s1_exp_b} - BIAS_X);
                s2_rm      <= s1_rm;
                s2_tag     <= s1_tag;
                s2_nan     <= any_nan | mul_invalid;
                s2_invalid <= s1_cls_a.snan | s1_cls_b.snan | mul_invalid;
                s2_inf     <= s1_cls_a.inf | s1_cls_b.inf;
                s2_zero    <= a_zero | b_zero;
            end
        end
    end

    fp_round_pack #(
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH)
    ) u_round_pack (
        .sign   (s2_sign),
        .exp_in (s2_exp),
        .prod   (s2_prod),
        .rm     (s2_rm),
        .result (rp_result),
        .flags  (rp_flags)
    );

    always_comb begin
        s3_result_d = rp_result;
        s3_flags_d  = rp_flags;
        if (s2_nan) begin
            s3_result_d        = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
            s3_flags_d         = '0;
            s3_flags_d.invalid = s2_invalid;
        end else if (s2_inf) begin
            s3_result_d = {s2_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            s3_flags_d  = '0;
        end else if (s2_zero) begin
            s3_result_d = {s2_sign, {(W-1){1'b0}}};
            s3_flags_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3       <= 1'b0;
            result   <= '0;
            out_tag  <= '0;
            s3_flags <= '0;
        end else if (s3_free) begin
            v3 <= v2;
            if (v2) begin
                result   <= s3_result_d;
                out_tag  <= s2_tag;
                s3_flags <= s3_flags_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - randomized scoreboard bench for fp_mul_pipe (FP32 configuration)
module tb_fp_mul_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  out_tag;
    logic [3:0]  flags;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        logic [3:0]  t;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] tag_next = 4'd0;
    bit         rand_ready = 1'b0;

    fp_mul_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rm        (rm),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h time=%0t", nm, act, req, $time);
        end
    endtask

    // Reference: exact integer product, then round by comparing the discarded remainder to half an ulp.
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m,
                                  output logic [31:0] r, output logic [3:0] f);
        logic s, xz, yz, xi, yi, xn, yn, xs, ys, inv0, inexact, up;
        int ex, ey, e, sh;
        longint unsigned ma, mb, p, q, rem, half;
        s    = x[31] ^ y[31];
        ex   = int'(x[30:23]);
        ey   = int'(y[30:23]);
        xz   = (ex == 0);
        yz   = (ey == 0);
        xi   = (ex == 255) && (x[22:0] == 23'h0);
        yi   = (ey == 255) && (y[22:0] == 23'h0);
        xn   = (ex == 255) && (x[22:0] != 23'h0);
        yn   = (ey == 255) && (y[22:0] != 23'h0);
        xs   = xn && !x[22];
        ys   = yn && !y[22];
        inv0 = (xz && yi) || (xi && yz);
        r = 32'h0;
        f = 4'h0;
        if (xn || yn || inv0) begin
            r    = 32'h7FC00000;
            f[3] = xs || ys || inv0;
        end else if (xi || yi) begin
            r = {s, 8'hFF, 23'h0};
        end else if (xz || yz) begin
            r = {s, 31'h0};
        end else begin
            ma = {40'h0, 1'b1, x[22:0]};
            mb = {40'h0, 1'b1, y[22:0]};
            p  = ma * mb;
            e  = ex + ey - 127;
            if (p >= (64'd1 << 47)) begin
                sh = 24;
                e  = e + 1;
            end else begin
                sh = 23;
            end
            q       = p >> sh;
            rem     = p - (q << sh);
            half    = 64'd1 << (sh - 1);
            inexact = (rem != 0);
            case (m)
                2'd0:    up = (rem > half) || ((rem == half) && q[0]);
                2'd1:    up = 1'b0;
                2'd2:    up = !s && inexact;
                default: up = s && inexact;
            endcase
            if (up) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = 64'd1 << 23;
                e = e + 1;
            end
            if (e >= 255) begin
                f = 4'b0101;
                if (m == 2'd0 || (m == 2'd2 && !s) || (m == 2'd3 && s))
                    r = {s, 8'hFF, 23'h0};
                else
                    r = {s, 8'hFE, 23'h7FFFFF};
            end else if (e <= 0) begin
                r = {s, 31'h0};
                f = 4'b0011;
            end else begin
                r = {s, 8'(e), q[22:0]};
                f = {3'b000, inexact};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = int'($urandom_range(0, 15));
        case (k)
            0:       v[30:0]  = 31'h0;
            1:       v[30:0]  = {8'hFF, 23'h0};
            2:       v[30:23] = 8'hFF;
            3:       v[30:23] = 8'h00;
            4:       v[30:23] = 8'(224 + $urandom_range(0, 30));
            5:       v[30:23] = 8'(1 + $urandom_range(0, 30));
            6:       begin v[30:23] = 8'd127; v[22:0] = 23'h7FFFFF - 23'($urandom_range(0, 3)); end
            default: v[30:23] = 8'(100 + $urandom_range(0, 54));
        endcase
        return v;
    endfunction

    // Single compare process: every cycle out_valid is high the head of the queue must be presented.
    always @(negedge clk) begin
        logic [31:0] mr;
        logic [3:0]  mf;
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("sb_result", result, exp_q[0].r);
                    chk("sb_flags", 32'(flags), 32'(exp_q[0].f));
                    chk("sb_tag", 32'(out_tag), 32'(exp_q[0].t));
                    if (out_ready) exp_q.delete(0);
                end
            end
            if (in_valid && in_ready) begin
                model(a, b, rm, mr, mf);
                exp_q.push_back('{r: mr, f: mf, t: in_tag});
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic directed(input string nm, input logic [31:0] x, input logic [31:0] y,
                            input logic [1:0] m, input logic [31:0] er, input logic [3:0] ef);
        int lat;
        a        = x;
        b        = y;
        rm       = m;
        in_tag   = tag_next;
        in_valid = 1'b1;
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'd3);
        chk({nm, "_result"}, result, er);
        chk({nm, "_flags"}, 32'(flags), 32'(ef));
        chk({nm, "_tag"}, 32'(out_tag), 32'(tag_next));
        tag_next = tag_next + 4'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
        bit acc;
        int budget;
        a        = x;
        b        = y;
        rm       = m;
        in_tag   = tag_next;
        in_valid = 1'b1;
        budget   = 0;
        acc      = 1'b0;
        while (!acc && budget < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        tag_next = tag_next + 4'd1;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_result", result, 32'h0);
        chk("rst_mid_flags", 32'(flags), 32'd0);
        exp_q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic burst(input int n, input int rst_beat);
        for (int i = 0; i < n; i++) begin
            if (i == rst_beat) pulse_reset();
            drive_beat(rand_op(), rand_op(), 2'($urandom_range(0, 3)));
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (exp_q.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_out_valid_idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        rm        = 2'd0;
        in_tag    = 4'h0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'h0);
        chk("reset_out_tag", 32'(out_tag), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        directed("mul_1p5x2",      32'h3FC00000, 32'h40000000, 2'd0, 32'h40400000, 4'b0000);
        directed("sticky_rne",     32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'b0001);
        directed("sticky_rtz",     32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 4'b0001);
        directed("ovf_rne",        32'h7F000000, 32'h40000000, 2'd0, 32'h7F800000, 4'b0101);
        directed("ovf_rtz",        32'h7F000000, 32'h40000000, 2'd1, 32'h7F7FFFFF, 4'b0101);
        directed("ovf_rdn",        32'h7F000000, 32'h40000000, 2'd3, 32'h7F7FFFFF, 4'b0101);
        directed("ovf_rup",        32'h7F000000, 32'h40000000, 2'd2, 32'h7F800000, 4'b0101);
        directed("ovf_neg_rup",    32'hFF000000, 32'h40000000, 2'd2, 32'hFF7FFFFF, 4'b0101);
        directed("ovf_neg_rdn",    32'hFF000000, 32'h40000000, 2'd3, 32'hFF800000, 4'b0101);
        directed("zero_x_inf",     32'h80000000, 32'h7F800000, 2'd0, 32'h7FC00000, 4'b1000);
        directed("snan_op",        32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b1000);
        directed("qnan_op",        32'h7FC00001, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b0000);
        directed("underflow",      32'h00800000, 32'h3F000000, 2'd0, 32'h00000000, 4'b0011);
        directed("min_normal_x1",  32'h00800000, 32'h3F800000, 2'd0, 32'h00800000, 4'b0000);
        directed("neg_inf_x2",     32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 4'b0000);
        directed("sub_flush",      32'h80000001, 32'h3F800000, 2'd0, 32'h80000000, 4'b0000);
        directed("round_carry",    32'h3FFFFFFE, 32'h3F800001, 2'd0, 32'h40000000, 4'b0001);
        directed("round_carry_rtz",32'h3FFFFFFE, 32'h3F800001, 2'd1, 32'h3FFFFFFF, 4'b0001);

        rand_ready = 1'b1;
        burst(300, -1);
        drain("burst_main");

        rand_ready = 1'b1;
        burst(16, 8);
        drain("burst_reset");

        rand_ready = 1'b1;
        burst(16, -1);
        drain("burst_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
